// File: rtl/ssqa_anneal_ctrl_if.sv
// Host/core-facing bus of the SSQA annealing sequencer: run control, latched config,
// sweep feedback from the core and the schedule/status outputs.
interface ssqa_anneal_ctrl_if #(
  parameter int TEM_WIDTH   = 8,
  parameter int ITER_WIDTH  = 16,
  parameter int TRIAL_WIDTH = 8,
  parameter int TAU_WIDTH   = 8
);
  logic                   start;
  logic                   abort;
  logic [TAU_WIDTH-1:0]   cfg_tau;
  logic [ITER_WIDTH-1:0]  cfg_cycles;
  logic [TRIAL_WIDTH-1:0] cfg_trials;
  logic [TEM_WIDTH-1:0]   cfg_i0_init;
  logic [TEM_WIDTH-1:0]   cfg_i0_step;
  logic [TEM_WIDTH-1:0]   cfg_i0_max;
  logic [TEM_WIDTH-1:0]   cfg_qmax;
  logic                   sweep_done;
  logic                   comp_en;
  logic                   rst_iter;
  logic [TEM_WIDTH-1:0]   I0;
  logic [TEM_WIDTH-1:0]   Q;
  logic [3:0]             state;
  logic [TRIAL_WIDTH-1:0] trial_idx;
  logic                   busy;
  logic                   trial_done;
  logic                   finish;
  logic                   aborted;

  // Host / core side.
  modport master (
    output start, abort, cfg_tau, cfg_cycles, cfg_trials,
           cfg_i0_init, cfg_i0_step, cfg_i0_max, cfg_qmax, sweep_done,
    input  comp_en, rst_iter, I0, Q, state, trial_idx, busy,
           trial_done, finish, aborted
  );

  // Sequencer side.
  modport slave (
    input  start, abort, cfg_tau, cfg_cycles, cfg_trials,
           cfg_i0_init, cfg_i0_step, cfg_i0_max, cfg_qmax, sweep_done,
    output comp_en, rst_iter, I0, Q, state, trial_idx, busy,
           trial_done, finish, aborted
  );
endinterface

// File: rtl/ssqa_anneal_ctrl.sv
// Multi-trial SSQA annealing sequencer: per trial runs a fixed number of spin sweeps,
// ramping I0 (saturating linear) and Q (+1, saturating) every tau sweeps.
module ssqa_anneal_ctrl #(
  parameter int TEM_WIDTH   = 8,
  parameter int ITER_WIDTH  = 16,
  parameter int TRIAL_WIDTH = 8,
  parameter int TAU_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst_sys,
  ssqa_anneal_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_INIT = 4'd1,
    S_RUN  = 4'd2,
    S_TEND = 4'd3,
    S_DONE = 4'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [TAU_WIDTH-1:0]   tau_q, tau_d;
  logic [ITER_WIDTH-1:0]  cycles_q, cycles_d;
  logic [TRIAL_WIDTH-1:0] trials_q, trials_d;
  logic [TEM_WIDTH-1:0]   i0_init_q, i0_init_d;
  logic [TEM_WIDTH-1:0]   i0_step_q, i0_step_d;
  logic [TEM_WIDTH-1:0]   i0_max_q, i0_max_d;
  logic [TEM_WIDTH-1:0]   qmax_q, qmax_d;
  logic [ITER_WIDTH-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic [TAU_WIDTH-1:0]   tau_cnt_q, tau_cnt_d;
  logic [TRIAL_WIDTH-1:0] trial_idx_q, trial_idx_d;
  logic [TEM_WIDTH-1:0]   i0_q, i0_d;
  logic [TEM_WIDTH-1:0]   q_q, q_d;

  logic comp_en, rst_iter, trial_done, finish, aborted;

  // One extra bit on both sums so the ceiling compare sees the true value, never a wrapped one.
  logic [TEM_WIDTH:0]   i0_sum, q_sum;
  logic [TEM_WIDTH-1:0] i0_sat, q_sat;

  always_comb begin
    i0_sum = {1'b0, i0_q} + {1'b0, i0_step_q};
    q_sum  = {1'b0, q_q} + {{TEM_WIDTH{1'b0}}, 1'b1};
    i0_sat = (i0_sum > {1'b0, i0_max_q}) ? i0_max_q : i0_sum[TEM_WIDTH-1:0];
    q_sat  = (q_sum > {1'b0, qmax_q}) ? qmax_q : q_sum[TEM_WIDTH-1:0];
  end

  // sweep_done is a fire-and-forget 1-cycle pulse (no ready): it is counted only in RUN
  // and dropped elsewhere; abort outranks it and every other transition.
  always_comb begin
    state_d     = state_q;
    tau_d       = tau_q;
    cycles_d    = cycles_q;
    trials_d    = trials_q;
    i0_init_d   = i0_init_q;
    i0_step_d   = i0_step_q;
    i0_max_d    = i0_max_q;
    qmax_d      = qmax_q;
    sweep_cnt_d = sweep_cnt_q;
    tau_cnt_d   = tau_cnt_q;
    trial_idx_d = trial_idx_q;
    i0_d        = i0_q;
    q_d         = q_q;
    comp_en     = 1'b0;
    rst_iter    = 1'b0;
    trial_done  = 1'b0;
    finish      = 1'b0;
    aborted     = 1'b0;

    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      aborted = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            tau_d       = (bus.cfg_tau == '0) ? TAU_WIDTH'(1) : bus.cfg_tau;
            cycles_d    = (bus.cfg_cycles == '0) ? ITER_WIDTH'(1) : bus.cfg_cycles;
            trials_d    = (bus.cfg_trials == '0) ? TRIAL_WIDTH'(1) : bus.cfg_trials;
            i0_init_d   = bus.cfg_i0_init;
            i0_step_d   = bus.cfg_i0_step;
            i0_max_d    = bus.cfg_i0_max;
            qmax_d      = bus.cfg_qmax;
            trial_idx_d = '0;
            state_d     = S_INIT;
          end
        end
        S_INIT: begin
          rst_iter    = 1'b1;
          i0_d        = i0_init_q;
          q_d         = '0;
          sweep_cnt_d = '0;
          tau_cnt_d   = '0;
          state_d     = S_RUN;
        end
        S_RUN: begin
          comp_en = 1'b1;
          if (bus.sweep_done) begin
            sweep_cnt_d = sweep_cnt_q + ITER_WIDTH'(1);
            tau_cnt_d   = tau_cnt_q + TAU_WIDTH'(1);
            if (tau_cnt_q == tau_q - TAU_WIDTH'(1)) begin
              tau_cnt_d = '0;
              i0_d      = i0_sat;
              q_d       = q_sat;
            end
            if (sweep_cnt_q == cycles_q - ITER_WIDTH'(1)) state_d = S_TEND;
          end
        end
        S_TEND: begin
          trial_done = 1'b1;
          if (trial_idx_q == trials_q - TRIAL_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            trial_idx_d = trial_idx_q + TRIAL_WIDTH'(1);
            state_d     = S_INIT;
          end
        end
        S_DONE: begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q     <= S_IDLE;
      tau_q       <= '0;
      cycles_q    <= '0;
      trials_q    <= '0;
      i0_init_q   <= '0;
      i0_step_q   <= '0;
      i0_max_q    <= '0;
      qmax_q      <= '0;
      sweep_cnt_q <= '0;
      tau_cnt_q   <= '0;
      trial_idx_q <= '0;
      i0_q        <= '0;
      q_q         <= '0;
    end else begin
      state_q     <= state_d;
      tau_q       <= tau_d;
      cycles_q    <= cycles_d;
      trials_q    <= trials_d;
      i0_init_q   <= i0_init_d;
      i0_step_q   <= i0_step_d;
      i0_max_q    <= i0_max_d;
      qmax_q      <= qmax_d;
      sweep_cnt_q <= sweep_cnt_d;
      tau_cnt_q   <= tau_cnt_d;
      trial_idx_q <= trial_idx_d;
      i0_q        <= i0_d;
      q_q         <= q_d;
    end
  end

  assign bus.comp_en    = comp_en;
  assign bus.rst_iter   = rst_iter;
  assign bus.trial_done = trial_done;
  assign bus.finish     = finish;
  assign bus.aborted    = aborted;
  assign bus.I0         = i0_q;
  assign bus.Q          = q_q;
  assign bus.state      = state_q;
  assign bus.trial_idx  = trial_idx_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ssqa_anneal_ctrl.sv
// Bench for ssqa_anneal_ctrl: directed and randomized runs against a closed-form
// schedule model (I0/Q as a function of sweeps completed in the trial).
module tb_ssqa_anneal_ctrl;

  localparam int TEM_WIDTH   = 8;
  localparam int ITER_WIDTH  = 16;
  localparam int TRIAL_WIDTH = 8;
  localparam int TAU_WIDTH   = 8;

  logic clk;
  logic rst_sys;

  ssqa_anneal_ctrl_if #(
    .TEM_WIDTH(TEM_WIDTH), .ITER_WIDTH(ITER_WIDTH),
    .TRIAL_WIDTH(TRIAL_WIDTH), .TAU_WIDTH(TAU_WIDTH)
  ) bus ();

  ssqa_anneal_ctrl #(
    .TEM_WIDTH(TEM_WIDTH), .ITER_WIDTH(ITER_WIDTH),
    .TRIAL_WIDTH(TRIAL_WIDTH), .TAU_WIDTH(TAU_WIDTH)
  ) dut (
    .clk    (clk),
    .rst_sys(rst_sys),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int n_trial_done;
  int n_rst_iter;
  int n_finish;

  // scoreboard: expected {I0, Q} after each sweep
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (bus.trial_done) n_trial_done++;
    if (bus.rst_iter)   n_rst_iter++;
    if (bus.finish)     n_finish++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Closed-form schedule: after k sweeps, floor(k/tau) steps have been applied.
  function automatic int model_i0(int k, int tau, int init, int step, int mx);
    int steps, v;
    steps = k / tau;
    if (steps == 0) return init;
    v = init + steps * step;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int model_q(int k, int tau, int qmax);
    int steps;
    steps = k / tau;
    return (steps > qmax) ? qmax : steps;
  endfunction

  task automatic scramble_cfg();
    bus.cfg_tau     = 8'($urandom);
    bus.cfg_cycles  = 16'($urandom);
    bus.cfg_trials  = 8'($urandom);
    bus.cfg_i0_init = 8'($urandom);
    bus.cfg_i0_step = 8'($urandom);
    bus.cfg_i0_max  = 8'($urandom);
    bus.cfg_qmax    = 8'($urandom);
  endtask

  // Drives one full run; abort_trial/abort_at (1-based sweep) < 0 / out of range means no abort.
  task automatic run(input int tau, input int cycles, input int trials, input int init,
                     input int step, input int mx, input int qmax,
                     input int abort_trial, input int abort_at);
    int et, ec, en, td0, ri0, fi0;
    logic [15:0] e;
    et = (tau == 0) ? 1 : tau;
    ec = (cycles == 0) ? 1 : cycles;
    en = (trials == 0) ? 1 : trials;
    @(negedge clk);
    bus.cfg_tau = 8'(tau);       bus.cfg_cycles = 16'(cycles); bus.cfg_trials = 8'(trials);
    bus.cfg_i0_init = 8'(init);  bus.cfg_i0_step = 8'(step);
    bus.cfg_i0_max = 8'(mx);     bus.cfg_qmax = 8'(qmax);
    bus.start = 1'b1;
    #1;
    check_eq("idle_state", 32'(bus.state), 0);
    check_eq("idle_busy", 32'(bus.busy), 0);
    td0 = n_trial_done; ri0 = n_rst_iter; fi0 = n_finish;
    @(negedge clk);
    bus.start = 1'b0;
    scramble_cfg();
    for (int t = 0; t < en; t++) begin
      bus.sweep_done = 1'($urandom_range(0, 1));
      #1;
      check_eq("init_state", 32'(bus.state), 1);
      check_eq("init_rst_iter", 32'(bus.rst_iter), 1);
      check_eq("init_comp_en", 32'(bus.comp_en), 0);
      check_eq("init_trial_idx", 32'(bus.trial_idx), 32'(t));
      @(negedge clk);
      bus.sweep_done = 1'b0;
      #1;
      check_eq("run_comp_en", 32'(bus.comp_en), 1);
      check_eq("run_i0_init", 32'(bus.I0), 32'(init));
      check_eq("run_q_init", 32'(bus.Q), 0);
      for (int k = 1; k <= ec; k++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.start = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        bus.start = 1'b0;
        bus.sweep_done = 1'b1;
        if (t == abort_trial && k == abort_at) begin
          bus.abort = 1'b1;
          #1;
          check_eq("abort_pulse", 32'(bus.aborted), 1);
          check_eq("abort_comp_en", 32'(bus.comp_en), 0);
          check_eq("abort_no_tdone", 32'(bus.trial_done), 0);
          @(negedge clk);
          bus.abort = 1'b0;
          bus.sweep_done = 1'b0;
          #1;
          check_eq("abort_state", 32'(bus.state), 0);
          check_eq("abort_aborted_clr", 32'(bus.aborted), 0);
          check_eq("abort_i0_hold", 32'(bus.I0), 32'(model_i0(k - 1, et, init, step, mx)));
          check_eq("abort_q_hold", 32'(bus.Q), 32'(model_q(k - 1, et, qmax)));
          check_eq("abort_no_finish", 32'(n_finish - fi0), 0);
          return;
        end
        #1;
        check_eq("sweep_comp_en", 32'(bus.comp_en), 1);
        exp_q.push_back({8'(model_i0(k, et, init, step, mx)), 8'(model_q(k, et, qmax))});
        @(negedge clk);
        bus.sweep_done = 1'b0;
        #1;
        e = exp_q.pop_front();
        check_eq("sweep_i0", 32'(bus.I0), 32'(e[15:8]));
        check_eq("sweep_q", 32'(bus.Q), 32'(e[7:0]));
        if (k < ec) check_eq("sweep_state_run", 32'(bus.state), 2);
      end
      check_eq("tend_state", 32'(bus.state), 3);
      check_eq("tend_trial_done", 32'(bus.trial_done), 1);
      check_eq("tend_comp_en", 32'(bus.comp_en), 0);
      @(negedge clk);
      bus.sweep_done = 1'($urandom_range(0, 1));
      if (t == en - 1) begin
        #1;
        check_eq("done_state", 32'(bus.state), 4);
        check_eq("done_finish", 32'(bus.finish), 1);
        check_eq("done_trial_idx", 32'(bus.trial_idx), 32'(en - 1));
        @(negedge clk);
        bus.sweep_done = 1'b0;
        #1;
        check_eq("end_state", 32'(bus.state), 0);
        check_eq("end_busy", 32'(bus.busy), 0);
        check_eq("end_i0_hold", 32'(bus.I0), 32'(model_i0(ec, et, init, step, mx)));
        check_eq("end_q_hold", 32'(bus.Q), 32'(model_q(ec, et, qmax)));
        check_eq("end_trial_idx", 32'(bus.trial_idx), 32'(en - 1));
      end
    end
    check_eq("cnt_trial_done", 32'(n_trial_done - td0), 32'(en));
    check_eq("cnt_rst_iter", 32'(n_rst_iter - ri0), 32'(en));
    check_eq("cnt_finish", 32'(n_finish - fi0), 1);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    bus.cfg_tau = 8'd1;     bus.cfg_cycles = 16'd8; bus.cfg_trials = 8'd2;
    bus.cfg_i0_init = 8'd5; bus.cfg_i0_step = 8'd2; bus.cfg_i0_max = 8'd100; bus.cfg_qmax = 8'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.sweep_done = 1'b1;
    @(negedge clk);
    bus.sweep_done = 1'b0;
    #1;
    check_eq("rst_pre_i0", 32'(bus.I0), 7);
    #2;
    rst_sys = 1'b0;
    bus.sweep_done = 1'b1;
    #1;
    check_eq("rst_state", 32'(bus.state), 0);
    check_eq("rst_i0", 32'(bus.I0), 0);
    check_eq("rst_q", 32'(bus.Q), 0);
    check_eq("rst_comp_en", 32'(bus.comp_en), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_sys = 1'b1;
    @(negedge clk);
    bus.sweep_done = 1'b0;
    #1;
    check_eq("rst_after_state", 32'(bus.state), 0);
    check_eq("rst_after_i0", 32'(bus.I0), 0);
    check_eq("rst_after_trial_idx", 32'(bus.trial_idx), 0);
  endtask

  initial begin
    int c, n, a_t, a_k;
    n_cmp = 0; n_err = 0;
    n_trial_done = 0; n_rst_iter = 0; n_finish = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.sweep_done = 1'b0;
    scramble_cfg();
    rst_sys = 1'b0;
    #12;
    check_eq("reset_state", 32'(bus.state), 0);
    check_eq("reset_i0", 32'(bus.I0), 0);
    check_eq("reset_q", 32'(bus.Q), 0);
    check_eq("reset_busy", 32'(bus.busy), 0);
    check_eq("reset_comp_en", 32'(bus.comp_en), 0);
    @(negedge clk);
    rst_sys = 1'b1;
    // abort ignored in IDLE
    bus.abort = 1'b1;
    #1;
    check_eq("idle_abort_ignored", 32'(bus.aborted), 0);
    bus.abort = 1'b0;

    run(2, 4, 1, 1, 3, 20, 10, -1, 0);
    run(1, 3, 1, 250, 10, 255, 1, -1, 0);
    run(1, 2, 3, 9, 4, 200, 5, -1, 0);
    run(2, 5, 2, 3, 7, 60, 4, 1, 3);
    run(3, 4, 1, 0, 5, 30, 2, -1, 0);
    run(0, 0, 0, 17, 6, 90, 3, -1, 0);
    reset_mid_run();
    run(2, 3, 2, 12, 40, 100, 1, -1, 0);

    for (int r = 0; r < 10; r++) begin
      c = $urandom_range(0, 5);
      n = $urandom_range(0, 3);
      a_t = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      a_k = $urandom_range(1, 5);
      run($urandom_range(0, 3), c, n, $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 4), a_t, a_k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
